// File: rtl/led_frame_loader_pkg.sv
// Shared types and constants for the LED frame loader.
package led_pkg;
  localparam int BYTES_PER_LED = 3;
  localparam int BITS_PER_LED  = 24;

  typedef enum logic [1:0] {IDLE, RECV, CHECK, COMMIT} loader_state_t;
endpackage

// File: rtl/led_frame_loader_spi_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives edge strobes.
module spi_sync (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic sdi,
  input  logic cs_n,
  output logic sck_rise,
  output logic cs_fall,
  output logic cs_rise,
  output logic sdi_s,
  output logic cs_s
);
  logic [2:0] r_sck;
  logic [2:0] r_cs;
  logic [1:0] r_sdi;

  // cs_n history resets low so a frame already in progress at reset release
  // never produces a falling edge; any spurious rise lands harmlessly in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck <= '0;
      r_cs  <= '0;
      r_sdi <= '0;
    end else begin
      r_sck <= {r_sck[1:0], sck};
      r_cs  <= {r_cs[1:0], cs_n};
      r_sdi <= {r_sdi[0], sdi};
    end
  end

  assign sck_rise = r_sck[1] & ~r_sck[2];
  assign cs_fall  = ~r_cs[1] & r_cs[2];
  assign cs_rise  = r_cs[1] & ~r_cs[2];
  assign sdi_s    = r_sdi[1];
  assign cs_s     = r_cs[1];
endmodule

// File: rtl/led_frame_loader.sv
// SPI-slave LED frame loader: shadow-buffers a frame and commits it atomically.
// Optional trailing checksum byte enabled by defining LED_FRAME_CHECKSUM_EN.
module led_frame_loader
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sck,
  input  logic                           sdi,
  input  logic                           cs_n,
  output logic [NUM_LEDS*BITS_PER_LED-1:0] color_string,
  output logic                           frame_stb,
  output logic                           frame_err,
  output logic                           busy
);
  localparam int W         = NUM_LEDS * BITS_PER_LED;
  localparam int NUM_BYTES = NUM_LEDS * BYTES_PER_LED;
`ifdef LED_FRAME_CHECKSUM_EN
  localparam int EXP_BYTES = NUM_BYTES + 1;
`else
  localparam int EXP_BYTES = NUM_BYTES;
`endif
  localparam int CNT_W = $clog2(EXP_BYTES + 2);

  logic w_sck_rise, w_cs_fall, w_cs_rise, w_sdi_s, w_cs_s;

  spi_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .sck      (sck),
    .sdi      (sdi),
    .cs_n     (cs_n),
    .sck_rise (w_sck_rise),
    .cs_fall  (w_cs_fall),
    .cs_rise  (w_cs_rise),
    .sdi_s    (w_sdi_s),
    .cs_s     (w_cs_s)
  );

  loader_state_t    r_state;
  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_byte;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_cs_pend;
  logic [W-1:0]     r_shadow;
  logic [W-1:0]     w_shadow_next;
  logic [7:0]       w_byte_full;
  logic             w_byte_done, w_byte_wr, w_recv_start, w_sum_ok, w_frame_ok;

  assign w_byte_full  = {r_byte, w_sdi_s};
  assign w_byte_done  = (r_state == RECV) && w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_byte_wr    = w_byte_done && (r_byte_cnt < CNT_W'(NUM_BYTES));
  assign w_recv_start = (r_state == IDLE) && (w_cs_fall || (r_cs_pend && !w_cs_s));

  // Byte 0 lands in the MSBs so LED0 ends up at the top of the string.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_shadow
      assign w_shadow_next[W-1-8*gi -: 8] =
        (w_byte_wr && (r_byte_cnt == CNT_W'(gi))) ? w_byte_full : r_shadow[W-1-8*gi -: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_shadow <= '0;
    else       r_shadow <= w_shadow_next;
  end

`ifdef LED_FRAME_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] r_cksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum   <= '0;
      r_cksum <= '0;
    end else if (w_recv_start) begin
      r_sum <= '0;
    end else begin
      if (w_byte_wr) r_sum <= r_sum + w_byte_full;
      if (w_byte_done && (r_byte_cnt == CNT_W'(NUM_BYTES))) r_cksum <= w_byte_full;
    end
  end

  assign w_sum_ok = (r_sum == r_cksum);
`else
  assign w_sum_ok = 1'b1;
`endif

  assign w_frame_ok = (r_bit_cnt == 3'd0) && (r_byte_cnt == CNT_W'(EXP_BYTES)) && w_sum_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_byte       <= '0;
      r_byte_cnt   <= '0;
      r_cs_pend    <= 1'b0;
      color_string <= '0;
      frame_stb    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      frame_err <= 1'b0;
      // Remember a new frame starting while the previous one is still being judged.
      if (w_cs_fall && (r_state != IDLE)) r_cs_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          r_cs_pend <= 1'b0;
          if (w_recv_start) begin
            r_state    <= RECV;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end
        end
        RECV: begin
          if (w_sck_rise) begin
            r_byte    <= w_byte_full[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done && (r_byte_cnt != CNT_W'(EXP_BYTES + 1)))
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
          end
          if (w_cs_rise) r_state <= CHECK;
        end
        CHECK: begin
          if (w_frame_ok) begin
            r_state <= COMMIT;
          end else begin
            frame_err <= 1'b1;
            r_state   <= IDLE;
          end
        end
        COMMIT: begin
          color_string <= r_shadow;
          frame_stb    <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader; expected values are hand-derived from the frame bytes.
module tb_led_frame_loader;
  localparam int NL = 6;
  localparam int W  = NL * 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic cs_n = 1'b1;
  logic [W-1:0] color_string;
  logic frame_stb, frame_err, busy;

  int tests = 0;
  int fails = 0;
  int n_stb, n_err, stb_at, err_at, tot_stb;
  logic [7:0] tx [0:31];
  logic [W-1:0] exp_g, exp_b, exp_cur;

  always #5 clk = ~clk;

  led_frame_loader #(.NUM_LEDS(NL)) dut (
    .clk          (clk),
    .reset        (reset),
    .sck          (sck),
    .sdi          (sdi),
    .cs_n         (cs_n),
    .color_string (color_string),
    .frame_stb    (frame_stb),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      sdi = b[i];
      wait_clk(4);
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
  endtask

  task automatic send_bytes(input int first, input int count);
    for (int k = first; k < first + count; k++) spi_bits(tx[k], 8);
  endtask

  task automatic open_frame();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  // Raises cs_n on a negedge and watches ncyc cycles; cycle c is the sample after the c-th posedge.
  task automatic close_frame(input int ncyc);
    wait_clk(4);
    cs_n = 1'b1;
    n_stb = 0; n_err = 0; stb_at = -1; err_at = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (frame_stb) begin n_stb++; if (stb_at < 0) stb_at = c; end
      if (frame_err) begin n_err++; if (err_at < 0) err_at = c; end
    end
  endtask

  function automatic logic [W-1:0] pack_tx();
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < NL * 3; i++) p[W-1-8*i -: 8] = tx[i];
    return p;
  endfunction

  task automatic fill(input logic [7:0] v, input int count);
    for (int i = 0; i < count; i++) tx[i] = v;
  endtask

  task automatic fill_g();
    for (int i = 0; i < 9; i++) tx[i] = (i % 3 == 0) ? 8'h00 : (i % 3 == 1) ? 8'hCE : 8'hFF;
    for (int i = 9; i < 18; i++) tx[i] = (i % 3 == 0) ? 8'h7F : (i % 3 == 1) ? 8'h32 : 8'hA8;
  endtask

  initial begin
    exp_g = 144'h00CEFF00CEFF00CEFF7F32A87F32A87F32A8;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);
    check("rst_color", color_string, '0);
    check("rst_stb", W'(frame_stb), '0);
    check("rst_err", W'(frame_err), '0);
    check("rst_busy", W'(busy), '0);

`ifdef LED_FRAME_CHECKSUM_EN
    // 18 x 0x10 sums to 0x120, so the wrapped checksum is 0x20.
    fill(8'h10, 18);
    tx[18] = 8'h20;
    open_frame();
    send_bytes(0, 19);
    check("ck_busy", W'(busy), W'(1));
    close_frame(10);
    check("ck_good_stb", W'(n_stb), W'(1));
    check("ck_good_lat", W'(stb_at), W'(5));
    check("ck_good_err", W'(n_err), '0);
    check("ck_good_color", color_string, {18{8'h10}});

    tx[18] = 8'h21;
    open_frame();
    send_bytes(0, 19);
    close_frame(10);
    check("ck_bad_err", W'(n_err), W'(1));
    check("ck_bad_lat", W'(err_at), W'(4));
    check("ck_bad_stb", W'(n_stb), '0);
    check("ck_bad_color", color_string, {18{8'h10}});

    fill(8'h10, 18);
    open_frame();
    send_bytes(0, 18);
    close_frame(10);
    check("ck_nosum_err", W'(n_err), W'(1));
    check("ck_nosum_color", color_string, {18{8'h10}});
`else
    fill_g();
    open_frame();
    send_bytes(0, 18);
    check("good_busy", W'(busy), W'(1));
    close_frame(10);
    check("good_stb_cnt", W'(n_stb), W'(1));
    check("good_stb_lat", W'(stb_at), W'(5));
    check("good_err_cnt", W'(n_err), '0);
    check("good_color", color_string, exp_g);
    check("idle_busy", W'(busy), '0);

    fill(8'h11, 17);
    open_frame();
    send_bytes(0, 17);
    close_frame(10);
    check("short_err_cnt", W'(n_err), W'(1));
    check("short_err_lat", W'(err_at), W'(4));
    check("short_stb_cnt", W'(n_stb), '0);
    check("short_color", color_string, exp_g);

    fill(8'h22, 19);
    open_frame();
    send_bytes(0, 19);
    close_frame(10);
    check("long_err_cnt", W'(n_err), W'(1));
    check("long_stb_cnt", W'(n_stb), '0);
    check("long_color", color_string, exp_g);

    fill(8'h33, 18);
    open_frame();
    send_bytes(0, 18);
    spi_bits(8'hE0, 3);
    close_frame(10);
    check("partial_err_cnt", W'(n_err), W'(1));
    check("partial_stb_cnt", W'(n_stb), '0);
    check("partial_color", color_string, exp_g);

    // Reset in the middle of a frame; the tail of that frame must be ignored.
    fill(8'h44, 18);
    open_frame();
    send_bytes(0, 9);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(1);
    check("midrst_busy", W'(busy), '0);
    check("midrst_color", color_string, '0);
    send_bytes(9, 9);
    close_frame(10);
    check("midrst_stb_cnt", W'(n_stb), '0);
    check("midrst_err_cnt", W'(n_err), '0);
    check("midrst_color_after", color_string, '0);

    fill_g();
    open_frame();
    send_bytes(0, 18);
    close_frame(10);
    check("postrst_stb_cnt", W'(n_stb), W'(1));
    check("postrst_color", color_string, exp_g);

    // Back-to-back frames with a six-cycle gap.
    for (int i = 0; i < 18; i++) tx[i] = 8'(i * 7 + 1);
    exp_cur = pack_tx();
    open_frame();
    send_bytes(0, 18);
    close_frame(6);
    tot_stb = n_stb;
    check("b2b_a_lat", W'(stb_at), W'(5));
    check("b2b_a_color", color_string, exp_cur);
    for (int i = 0; i < 18; i++) tx[i] = 8'hFF - 8'(i);
    exp_b = 144'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0EFEE;
    open_frame();
    send_bytes(0, 18);
    close_frame(10);
    tot_stb += n_stb;
    check("b2b_stb_total", W'(tot_stb), W'(2));
    check("b2b_err", W'(n_err), '0);
    check("b2b_color", color_string, exp_b);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_frame_loader.md
# led_frame_loader

SPI-slave frame loader that receives LED color frames from the MCU and presents a stable, atomically updated color string to the WS2812 serializer (`led_shifter`). It sits directly upstream of the serializer in the FPGA top level, runs on the 24 MHz HSOSC clock and replaces the hard-coded color constants. Bytes are shadow-buffered during reception and committed only when a complete, well-formed frame has been received.

## Interface
- `NUM_LEDS`, default 6: number of LEDs per frame; color string width is `NUM_LEDS*24`.
- `clk` input, 1 bit: 24 MHz system clock.
- `reset` input, 1 bit: synchronous, active-high.
- `sck` input, 1 bit: SPI clock from MCU, asynchronous to `clk`, maximum 3 MHz.
- `sdi` input, 1 bit: SPI data from MCU.
- `cs_n` input, 1 bit: SPI chip select, active-low, asynchronous.
- `color_string` output, `NUM_LEDS*24` bits: committed frame, GRB per LED, LED0 in the MSBs; connects to the serializer's color input.
- `frame_stb` output, 1 bit: one-cycle pulse on commit.
- `frame_err` output, 1 bit: one-cycle pulse on frame rejection.
- `busy` output, 1 bit: high while a frame is being received.

## Operation
- SPI mode 0, MSB first. `sdi` is sampled on the synchronized rising edge of `sck`.
- `sck`, `sdi` and `cs_n` each pass through a 2-flop synchronizer. Edges are detected in the `clk` domain.
- States:
  - IDLE: waits for synchronized `cs_n` falling edge, then goes to RECV. On entry to RECV the bit and byte counters are cleared.
  - RECV: each `sck` rise shifts one bit into the byte register. Every 8 bits, the byte is written into the shadow buffer at byte index `byte_cnt` (first byte goes to bits `[W-1:W-8]`) and `byte_cnt` increments. Synchronized `cs_n` rising edge goes to CHECK.
  - CHECK: one cycle. The frame is good if bit count mod 8 is 0 and `byte_cnt` equals `3*NUM_LEDS` (plus 1 with checksum). Good goes to COMMIT; bad pulses `frame_err` and returns to IDLE.
  - COMMIT: one cycle. Copies shadow to `color_string`, pulses `frame_stb`, returns to IDLE.
- Bytes beyond the expected count are not written (`byte_cnt` saturates at expected+1) and the frame fails CHECK. Partial trailing bits also fail CHECK.
- `color_string` changes only in COMMIT. A rejected frame leaves the previous value intact.
- `busy` is high in RECV, CHECK and COMMIT.
- A `cs_n` falling edge while in CHECK or COMMIT is not lost. The FSM enters RECV on the cycle after returning to IDLE if synchronized `cs_n` is still low.

## Timing
- Reset values: `color_string` = 0, `frame_stb` = 0, `frame_err` = 0, `busy` = 0, state = IDLE, counters = 0, shadow = 0.
- Reset mid-frame aborts reception. No commit occurs and no `frame_err` is pulsed.
- Latency:
  - `cs_n` rise at pin → `frame_stb` and new `color_string`: 5 `clk` cycles (2 synchronizer, 1 edge detect, 1 CHECK, 1 COMMIT).
  - Error path: `frame_err` asserts 4 cycles after the `cs_n` rise.
- `frame_stb` and `frame_err` are never high in the same cycle.
- `sck` high and low times must each be ≥ 3 `clk` periods. Gap between frames must be ≥ 6 `clk` periods.

## Configuration
- `LED_FRAME_CHECKSUM_EN` defined:
  - Frame length is `3*NUM_LEDS+1` bytes. The final byte must equal the 8-bit wrapping sum of all color bytes.
  - On mismatch the frame is rejected with `frame_err`.
  - The checksum byte is not stored in `color_string`.
- Not defined: frame length is `3*NUM_LEDS` bytes and no checksum is computed.

## Structure
- Package `led_pkg`:
  - `BYTES_PER_LED` = 3, `BITS_PER_LED` = 24.
  - `loader_state_t` enum {IDLE, RECV, CHECK, COMMIT}.
- Sub-module `spi_sync`:
  - 2-flop synchronizer for `sck`, `sdi`, `cs_n`.
  - Outputs `sck_rise`, `cs_fall`, `cs_rise`, `sdi_s`.
  - Instantiated once.
- The shadow buffer is a flat `NUM_LEDS*24`-bit register. No SPRAM is used.

## Test plan
- Good frame, `NUM_LEDS`=6, checksum off: 18 bytes {00,CE,FF ×3, 7F,32,A8 ×3} → `frame_stb` once, 5 cycles after `cs_n` rise. `color_string` = 0x00CEFF00CEFF00CEFF7F32A87F32A87F32A8.
- Short frame (17 bytes) after the good frame → `frame_err` pulse, no `frame_stb`, `color_string` unchanged.
- Long frame (19 bytes) and a frame with 18 bytes + 3 bits → `frame_err` each time, `color_string` unchanged.
- Checksum on: 18 bytes all 0x10 plus checksum 0x20 → commit. The same frame with checksum 0x21 → `frame_err`.
- Reset asserted after byte 9 of a frame → state IDLE, `color_string` = 0, no strobe. The next full frame commits normally.
- Back-to-back frames with a 6-cycle gap, contents A then B → two `frame_stb` pulses, final `color_string` = B.
